// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program as a byte stream over valid/ready and
// packs it little-endian into 32-bit words. Each word is written to the next
// instruction-memory word address, starting at BASE_ADDR. The CPU is held in
// reset until a well-formed stream has been fully written.
//
// Ports:
//   clk, reset            single clock; asynchronous active-high reset
//   in_valid/in_ready     byte handshake; in_data is the byte, in_last marks the final byte
//   mem_we/mem_addr/
//   mem_wdata             one-cycle instruction-memory write port
//   cpu_reset             high until the load completes successfully
//   done / error          sticky completion / malformed-stream flags
//   word_count            number of words written so far
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 64,
  localparam int unsigned CNT_W = $clog2(MAX_WORDS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_reset,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        word_q, word_d;        // lanes 0..2; lane 3 comes straight from in_data
  logic               last_pending_q, last_pending_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_we_q, mem_we_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               accept_c;

  assign accept_c = in_valid & in_ready_q;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_LOAD;
      byte_idx_q     <= 2'd0;
      word_q         <= 24'd0;
      last_pending_q <= 1'b0;
      word_count_q   <= '0;
      mem_addr_q     <= BASE_ADDR;
      mem_wdata_q    <= 32'd0;
      in_ready_q     <= 1'b1;
      mem_we_q       <= 1'b0;
      cpu_reset_q    <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      last_pending_q <= last_pending_d;
      word_count_q   <= word_count_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      cpu_reset_q    <= cpu_reset_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so that they
  // register on the same edge that enters each state.
  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    last_pending_d = last_pending_q;
    word_count_d   = word_count_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;

    unique case (state_q)
      ST_LOAD: begin
        if (accept_c) begin
          if (word_count_q == CNT_W'(MAX_WORDS)) begin
            // Capacity exhausted: the byte is consumed and the load fails.
            state_d = ST_ERROR;
          end else if (byte_idx_q == 2'd3) begin
            state_d        = ST_WRITE;
            byte_idx_d     = 2'd0;
            last_pending_d = in_last;
            mem_addr_d     = BASE_ADDR + (32'(word_count_q) << 2);
            mem_wdata_d    = {in_data, word_q};
          end else if (in_last) begin
            // Stream ended mid-word.
            state_d = ST_ERROR;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            unique case (byte_idx_q)
              2'd0:    word_d[7:0]   = in_data;
              2'd1:    word_d[15:8]  = in_data;
              default: word_d[23:16] = in_data;
            endcase
          end
        end
      end
      ST_WRITE: begin
        word_count_d = word_count_q + CNT_W'(1);
        state_d      = last_pending_q ? ST_DONE : ST_LOAD;
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    in_ready_d  = (state_d == ST_LOAD);
    mem_we_d    = (state_d == ST_WRITE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    cpu_reset_d = (state_d != ST_DONE);
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule
